spec_free_list_ckpt: RTL
========================

// Module: spec_free_list_ckpt
// PURPOSE
//  Parametrised speculative physical-register free list for the rename stage.
//  Circular buffer of free physical tags: up to DISPATCH_W tags popped per cycle at head, up to COMMIT_W pushed at tail.
//  NUM_CKPT head checkpoints for branch recovery, plus full flush recovery.
//  Successor to the fixed 4-wide free list: per-lane compacted pops, indexed checkpoints, wrap-bit pointers.
// PARAMETERS
//  DEPTH       96  free-list entries (= PHYS_REGS - ARCH_REGS); any value >= DISPATCH_W
//  PHYS_REGS  128  physical registers; PREG_W = $clog2(PHYS_REGS)
//  ARCH_REGS   32  architectural registers; tags 0..ARCH_REGS-1 are mapped at reset
//  DISPATCH_W   4  allocation lanes
//  COMMIT_W     4  free (commit) lanes
//  NUM_CKPT     8  checkpoint slots; CK_W = $clog2(NUM_CKPT)
// PORTS
//  clk             in   1                    clock; all state updates on rising edge
//  reset_n         in   1                    async active-low reset
//  stall_i         in   1                    rename stalled: no pop this cycle
//  alloc_req_i     in   DISPATCH_W           per-lane tag request mask
//  alloc_ready_o   out  1                    count >= DISPATCH_W
//  alloc_reg_o     out  DISPATCH_W*PREG_W    lane k tag (valid only where requested)
//  free_val_i      in   COMMIT_W             per-lane free valid
//  free_reg_i      in   COMMIT_W*PREG_W      tags being freed
//  ckpt_take_i     in   1                    capture head into slot ckpt_id_i
//  ckpt_id_i       in   CK_W                 slot to write
//  ckpt_restore_i  in   1                    restore head from slot rst_id_i
//  rst_id_i        in   CK_W                 slot to restore
//  recover_all_i   in   1                    flush: every non-committed tag returns
//  count_o         out  $clog2(DEPTH+1)      current free count
//  overflow_err_o  out  1                    sticky: push would exceed DEPTH
// BEHAVIOUR
//  Reset (async, reset_n=0): head=0, tail=0, count=DEPTH, entry i = ARCH_REGS+i,
//   all checkpoint slots = 0, overflow_err_o=0, alloc_ready_o=1 (DEPTH>=DISPATCH_W).
//  Pointers: head/tail carry one wrap bit; index wraps DEPTH-1 -> 0 (non-pow2 safe).
//   count = tail - head in wrap space.
//  Pop: fire = alloc_ready_o & ~stall_i & ~ckpt_restore_i & ~recover_all_i.
//   Lane k gets entry head+popcount(alloc_req_i[k-1:0]) (compacted, age order).
//   alloc_reg_o is combinational from the array, same cycle.
//   On fire, head += popcount(alloc_req_i) next edge. All-or-nothing: no partial pop when count < DISPATCH_W.
//  Push: lanes with free_val_i written compacted at tail..tail+n-1; tail += n.
//   Pushes are never blocked (stall, restore, recover all still push).
//   Tags pushed in cycle t are poppable from cycle t+1; no bypass.
//   If count_next would exceed DEPTH, the push is dropped and overflow_err_o is set until reset.
//  Checkpoint take: slot[ckpt_id_i] <= head_next, i.e. head after this cycle's pop.
//   Ignored if restore or recover_all is asserted in the same cycle.
//  Restore: head <= slot[rst_id_i]; count <= tail_next - slot head.
//  Recover all: head <= tail_next - DEPTH (wrap space), count <= DEPTH.
//  Priority: recover_all_i > ckpt_restore_i > pop; push applies in all cases.
//  Widths: popcounts are $clog2(W+1) bits. Pointer arithmetic uses PTR_W+1 bits with explicit modulo, never silent truncation.
//  Reset mid-operation: state returns to the reset values immediately; in-flight requests are dropped.
// STRUCTURE
//  rename_pkg: PHYS_REGS, ARCH_REGS, DISPATCH_W, COMMIT_W, NUM_CKPT, derived PREG_W/CK_W, free_ptr_t (wrap bit + index).
//  Sub-module free_list_ram: DEPTH x PREG_W, DISPATCH_W async read ports, COMMIT_W write ports, reset-initialised contents.
//  Top holds pointers, count, checkpoint array, compaction muxes.
// TESTING
//  Reset, all 4 lanes req, no stall -> tags 32,33,34,35; next cycle count=92, head=4.
//  alloc_req_i=4'b1010 at head=0 -> lane1=32, lane3=33; head=2.
//  count=3, alloc_req_i=4'hF -> alloc_ready_o=0, head unchanged. Same cycle free 2 tags -> count=5, ready=1 next cycle.
//  Take ckpt slot 2 while allocating 2 at head=10 -> slot2=12. Pop 8, then restore slot 2 with 1 free
//   -> head=12, count = tail_next - 12.
//  Wrap: head=94, pop 4 -> lanes read idx 94,95,0,1; head=2 with wrap bit toggled. Tail wraps the same way.
//  recover_all_i with 3 frees -> count=DEPTH, stall ignored. Deassert reset_n mid-burst -> reset values asynchronously.

Source files
------------

// File: rtl/rename_pkg.sv
// Rename-stage shared parameters and the free-list pointer type.
// Pointers carry a wrap bit above a 0..DEPTH-1 index.
package rename_pkg;

    localparam int DEF_DEPTH      = 96;
    localparam int DEF_PHYS_REGS  = 128;
    localparam int DEF_ARCH_REGS  = 32;
    localparam int DEF_DISPATCH_W = 4;
    localparam int DEF_COMMIT_W   = 4;
    localparam int DEF_NUM_CKPT   = 8;

    localparam int DEF_PREG_W = $clog2(DEF_PHYS_REGS);
    localparam int DEF_CK_W   = $clog2(DEF_NUM_CKPT);
    localparam int DEF_PTR_W  = $clog2(DEF_DEPTH);

    typedef struct packed {
        logic                 wrap;
        logic [DEF_PTR_W-1:0] idx;
    } free_ptr_t;

endpackage

// File: rtl/free_list_ram.sv
// Free-tag storage: async read ports for allocation lanes,
// synchronous write ports for commit lanes, reset to ARCH_REGS+i.
module free_list_ram #(
    parameter int DEPTH     = 96,
    parameter int PREG_W    = 7,
    parameter int ARCH_REGS = 32,
    parameter int RD_N      = 4,
    parameter int WR_N      = 4,
    parameter int AW        = 7
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [RD_N-1:0][AW-1:0]    raddr_i,
    output logic [RD_N-1:0][PREG_W-1:0] rdata_o,
    input  logic [WR_N-1:0]            we_i,
    input  logic [WR_N-1:0][AW-1:0]    waddr_i,
    input  logic [WR_N-1:0][PREG_W-1:0] wdata_i
);

    logic [PREG_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= PREG_W'(ARCH_REGS + i);
            end
        end else begin
            // Compacted lanes never share an address.
            for (int k = 0; k < WR_N; k++) begin
                if (we_i[k]) begin
                    mem_q[waddr_i[k]] <= wdata_i[k];
                end
            end
        end
    end

    always_comb begin
        for (int k = 0; k < RD_N; k++) begin
            rdata_o[k] = mem_q[raddr_i[k]];
        end
    end

endmodule

// File: rtl/spec_free_list_ckpt.sv
// Speculative physical-register free list with indexed head checkpoints.
// count is derived from wrap-bit pointers; DEPTH need not be a power of two.
module spec_free_list_ckpt
    import rename_pkg::*;
#(
    parameter int DEPTH      = DEF_DEPTH,
    parameter int PHYS_REGS  = DEF_PHYS_REGS,
    parameter int ARCH_REGS  = DEF_ARCH_REGS,
    parameter int DISPATCH_W = DEF_DISPATCH_W,
    parameter int COMMIT_W   = DEF_COMMIT_W,
    parameter int NUM_CKPT   = DEF_NUM_CKPT
) (
    input  logic                                    clk,
    input  logic                                    reset_n,
    input  logic                                    stall_i,
    input  logic [DISPATCH_W-1:0]                   alloc_req_i,
    output logic                                    alloc_ready_o,
    output logic [DISPATCH_W*$clog2(PHYS_REGS)-1:0] alloc_reg_o,
    input  logic [COMMIT_W-1:0]                     free_val_i,
    input  logic [COMMIT_W*$clog2(PHYS_REGS)-1:0]   free_reg_i,
    input  logic                                    ckpt_take_i,
    input  logic [$clog2(NUM_CKPT)-1:0]             ckpt_id_i,
    input  logic                                    ckpt_restore_i,
    input  logic [$clog2(NUM_CKPT)-1:0]             rst_id_i,
    input  logic                                    recover_all_i,
    output logic [$clog2(DEPTH+1)-1:0]              count_o,
    output logic                                    overflow_err_o
);

    localparam int PREG_W = $clog2(PHYS_REGS);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH+1);
    localparam int PD_W   = $clog2(DISPATCH_W+1);
    localparam int PC_W   = $clog2(COMMIT_W+1);
    localparam logic [PTR_W:0] DEPTH_P = (PTR_W+1)'(DEPTH);

    typedef struct packed {
        logic             wrap;
        logic [PTR_W-1:0] idx;
    } ptr_t;

    function automatic ptr_t ptr_add(ptr_t p, logic [PTR_W:0] n);
        logic [PTR_W:0] s;
        ptr_t r;
        s = {1'b0, p.idx} + n;
        if (s >= DEPTH_P) begin
            r.idx  = PTR_W'(s - DEPTH_P);
            r.wrap = ~p.wrap;
        end else begin
            r.idx  = s[PTR_W-1:0];
            r.wrap = p.wrap;
        end
        return r;
    endfunction

    function automatic logic [PTR_W:0] ptr_dist(ptr_t a, ptr_t b);
        if (a.wrap == b.wrap) begin
            return {1'b0, a.idx} - {1'b0, b.idx};
        end
        return {1'b0, a.idx} + DEPTH_P - {1'b0, b.idx};
    endfunction

    ptr_t head_q, head_d;
    ptr_t tail_q, tail_d;
    ptr_t head_pop, head_base;
    ptr_t slot_q [NUM_CKPT];
    logic ovf_q, ovf_d;

    logic [PD_W-1:0] rd_off [DISPATCH_W];
    logic [PD_W-1:0] n_pop;
    logic [PC_W-1:0] wr_off [COMMIT_W];
    logic [PC_W-1:0] n_push;

    logic [PTR_W:0] cnt, avail;
    logic ready, fire, push_ok, ck_we;

    logic [DISPATCH_W-1:0][PTR_W-1:0]  raddr;
    logic [DISPATCH_W-1:0][PREG_W-1:0] rdata;
    logic [COMMIT_W-1:0][PTR_W-1:0]    waddr;
    logic [COMMIT_W-1:0]               we;

    always_comb begin
        rd_off[0] = '0;
        for (int k = 1; k < DISPATCH_W; k++) begin
            rd_off[k] = rd_off[k-1] + PD_W'(alloc_req_i[k-1]);
        end
        n_pop = rd_off[DISPATCH_W-1] + PD_W'(alloc_req_i[DISPATCH_W-1]);
    end

    always_comb begin
        wr_off[0] = '0;
        for (int k = 1; k < COMMIT_W; k++) begin
            wr_off[k] = wr_off[k-1] + PC_W'(free_val_i[k-1]);
        end
        n_push = wr_off[COMMIT_W-1] + PC_W'(free_val_i[COMMIT_W-1]);
    end

    always_comb begin
        cnt   = ptr_dist(tail_q, head_q);
        ready = cnt >= (PTR_W+1)'(DISPATCH_W);
        fire  = ready & ~stall_i & ~ckpt_restore_i & ~recover_all_i;

        head_pop  = fire ? ptr_add(head_q, (PTR_W+1)'(n_pop)) : head_q;
        head_base = ckpt_restore_i ? slot_q[rst_id_i] : head_pop;
        avail     = ptr_dist(tail_q, head_base);

        // A flush rebuilds the full list, so it can never overflow.
        push_ok = recover_all_i |
                  (({1'b0, avail} + (PTR_W+2)'(n_push)) <= (PTR_W+2)'(DEPTH));
        tail_d  = push_ok ? ptr_add(tail_q, (PTR_W+1)'(n_push)) : tail_q;
        head_d  = recover_all_i ? {~tail_d.wrap, tail_d.idx} : head_base;
        ovf_d   = ovf_q | (~push_ok & (n_push != '0));
        ck_we   = ckpt_take_i & ~ckpt_restore_i & ~recover_all_i;
    end

    always_comb begin
        ptr_t rp;
        ptr_t wp;
        for (int k = 0; k < DISPATCH_W; k++) begin
            rp       = ptr_add(head_q, (PTR_W+1)'(rd_off[k]));
            raddr[k] = rp.idx;
        end
        for (int k = 0; k < COMMIT_W; k++) begin
            wp       = ptr_add(tail_q, (PTR_W+1)'(wr_off[k]));
            waddr[k] = wp.idx;
            we[k]    = free_val_i[k] & push_ok;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q <= '0;
            tail_q <= '{wrap: 1'b1, idx: '0};
            ovf_q  <= 1'b0;
            for (int i = 0; i < NUM_CKPT; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            ovf_q  <= ovf_d;
            if (ck_we) begin
                slot_q[ckpt_id_i] <= head_pop;
            end
        end
    end

    free_list_ram #(
        .DEPTH     (DEPTH),
        .PREG_W    (PREG_W),
        .ARCH_REGS (ARCH_REGS),
        .RD_N      (DISPATCH_W),
        .WR_N      (COMMIT_W),
        .AW        (PTR_W)
    ) u_ram (
        .clk     (clk),
        .reset_n (reset_n),
        .raddr_i (raddr),
        .rdata_o (rdata),
        .we_i    (we),
        .waddr_i (waddr),
        .wdata_i (free_reg_i)
    );

    assign alloc_reg_o    = rdata;
    assign alloc_ready_o  = ready;
    assign count_o        = CNT_W'(cnt);
    assign overflow_err_o = ovf_q;

endmodule
